// File: rtl/ucsbece154b_bp_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings, PHT reset value,
// index-width helper and the saturating counter step.
package ucsbece154b_bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } phtCounter_t;

    localparam phtCounter_t PHT_RESET = WNT;

    function automatic int unsigned idxWidth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic phtCounter_t counterNext(input phtCounter_t c, input logic taken);
        case (c)
            SNT:     return taken ? WNT : SNT;
            WNT:     return taken ? WT  : SNT;
            WT:      return taken ? ST  : WNT;
            ST:      return taken ? ST  : WT;
            default: return c;
        endcase
    endfunction

endpackage

// File: rtl/ucsbece154b_btb.sv
// Direct-mapped branch target buffer: valid/tag/target/jump storage, tag compare
// and a single write port. Conflicting tags simply overwrite.
module ucsbece154b_btb
    import ucsbece154b_bp_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookupPc,
    output logic        hit,
    output logic        jump,
    output logic [31:0] target,
    input  logic        writeEn,
    input  logic [31:0] writePc,
    input  logic [31:0] writeTarget,
    input  logic        writeJump
);

    localparam int unsigned IDX  = idxWidth(NUM_ENTRIES);
    localparam int unsigned TAGW = 30 - IDX;

    logic [NUM_ENTRIES-1:0] valid;
    logic [NUM_ENTRIES-1:0] jumpBits;
    logic [TAGW-1:0]        tags    [NUM_ENTRIES];
    logic [31:0]            targets [NUM_ENTRIES];

    logic [IDX-1:0]  lookupIdx, writeIdx;
    logic [TAGW-1:0] lookupTag, writeTag;

    // Byte-offset bits never take part in indexing or tagging.
    logic unusedPcBits;
    assign unusedPcBits = ^{lookupPc[1:0], writePc[1:0]};

    assign lookupIdx = lookupPc[IDX+1:2];
    assign lookupTag = lookupPc[31:IDX+2];
    assign writeIdx  = writePc[IDX+1:2];
    assign writeTag  = writePc[31:IDX+2];

    assign hit    = valid[lookupIdx] && (tags[lookupIdx] == lookupTag);
    assign jump   = jumpBits[lookupIdx];
    assign target = targets[lookupIdx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (writeEn) begin
            valid[writeIdx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (writeEn && reset) begin
            tags[writeIdx]     <= writeTag;
            targets[writeIdx]  <= writeTarget;
            jumpBits[writeIdx] <= writeJump;
        end
    end

endmodule

// File: rtl/ucsbece154b_branch_predictor.sv
// BTB + 2-bit PHT branch predictor. Define UCSBECE154B_GSHARE_EN for gshare
// indexing (pc XOR GHR); otherwise bimodal with the GHR tied to zero.
module ucsbece154b_branch_predictor
    import ucsbece154b_bp_pkg::*;
#(
    parameter int unsigned NUM_BTB_ENTRIES = 32,
    parameter int unsigned NUM_GHR_BITS    = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             pc_i,
    output logic                    predict_taken_o,
    output logic [31:0]             predict_target_o,
    output logic                    btb_hit_o,
    output logic [NUM_GHR_BITS-1:0] ghr_o,
    input  logic                    update_valid_i,
    input  logic [31:0]             update_pc_i,
    input  logic [31:0]             update_target_i,
    input  logic                    update_taken_i,
    input  logic                    update_is_branch_i,
    input  logic                    update_is_jump_i,
    input  logic [NUM_GHR_BITS-1:0] update_ghr_i
);

    localparam int unsigned PHT_DEPTH = 1 << NUM_GHR_BITS;

    logic [NUM_GHR_BITS-1:0] ghr;
    logic [NUM_GHR_BITS-1:0] lookupIdx, updateIdx;
    phtCounter_t             pht [PHT_DEPTH];
    logic [1:0]              lookupCtr;

    logic        btbHit, btbJump, btbWriteEn, phtWriteEn;
    logic [31:0] btbTarget;

    assign phtWriteEn = update_valid_i && update_is_branch_i;
    assign btbWriteEn = update_valid_i && update_taken_i && (update_is_branch_i || update_is_jump_i);

`ifdef UCSBECE154B_GSHARE_EN
    assign lookupIdx = pc_i[NUM_GHR_BITS+1:2] ^ ghr;
    assign updateIdx = update_pc_i[NUM_GHR_BITS+1:2] ^ update_ghr_i;

    // History is rebuilt from the snapshot so a mispredict repairs it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
        end else if (phtWriteEn) begin
            ghr <= {update_ghr_i[NUM_GHR_BITS-2:0], update_taken_i};
        end
    end
`else
    logic unusedGhrSnapshot;
    assign unusedGhrSnapshot = ^update_ghr_i;

    assign lookupIdx = pc_i[NUM_GHR_BITS+1:2];
    assign updateIdx = update_pc_i[NUM_GHR_BITS+1:2];
    assign ghr       = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht[i] <= PHT_RESET;
            end
        end else if (phtWriteEn) begin
            pht[updateIdx] <= counterNext(pht[updateIdx], update_taken_i);
        end
    end

    ucsbece154b_btb #(
        .NUM_ENTRIES(NUM_BTB_ENTRIES)
    ) btb (
        .clk        (clk),
        .reset      (reset),
        .lookupPc   (pc_i),
        .hit        (btbHit),
        .jump       (btbJump),
        .target     (btbTarget),
        .writeEn    (btbWriteEn),
        .writePc    (update_pc_i),
        .writeTarget(update_target_i),
        .writeJump  (update_is_jump_i)
    );

    assign lookupCtr        = pht[lookupIdx];
    assign btb_hit_o        = btbHit;
    assign predict_taken_o  = btbHit && (btbJump || lookupCtr[1]);
    assign predict_target_o = btbHit ? btbTarget : (pc_i + 32'd4);
    assign ghr_o            = ghr;

endmodule

// File: tb/tb_ucsbece154b_branch_predictor.sv
// Scoreboard bench for the branch predictor (4-entry BTB so aliasing is easy to hit).
module tb_ucsbece154b_branch_predictor;

    localparam int unsigned GB = 5;
`ifdef UCSBECE154B_GSHARE_EN
    localparam logic [GB-1:0] GHR_AFTER = 5'b01101;
`else
    localparam logic [GB-1:0] GHR_AFTER = 5'b00000;
`endif

    typedef struct packed {
        logic          hit;
        logic          taken;
        logic [31:0]   target;
        logic [GB-1:0] ghr;
        logic [31:0]   pc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   pc_i;
    logic          predict_taken_o;
    logic [31:0]   predict_target_o;
    logic          btb_hit_o;
    logic [GB-1:0] ghr_o;
    logic          update_valid_i;
    logic [31:0]   update_pc_i;
    logic [31:0]   update_target_i;
    logic          update_taken_i;
    logic          update_is_branch_i;
    logic          update_is_jump_i;
    logic [GB-1:0] update_ghr_i;

    exp_t sb[$];
    logic chk = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ucsbece154b_branch_predictor #(
        .NUM_BTB_ENTRIES(4),
        .NUM_GHR_BITS   (GB)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .pc_i              (pc_i),
        .predict_taken_o   (predict_taken_o),
        .predict_target_o  (predict_target_o),
        .btb_hit_o         (btb_hit_o),
        .ghr_o             (ghr_o),
        .update_valid_i    (update_valid_i),
        .update_pc_i       (update_pc_i),
        .update_target_i   (update_target_i),
        .update_taken_i    (update_taken_i),
        .update_is_branch_i(update_is_branch_i),
        .update_is_jump_i  (update_is_jump_i),
        .update_ghr_i      (update_ghr_i)
    );

    // Monitor: one queued expectation per strobed lookup, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk) begin
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL lookup pc=%h: no expectation queued", pc_i);
            end else begin
                exp_t e;
                e = sb.pop_front();
                vectors++;
                if ({btb_hit_o, predict_taken_o, predict_target_o, ghr_o} !==
                    {e.hit, e.taken, e.target, e.ghr}) begin
                    miscompares++;
                    $display("FAIL lookup pc=%h: got hit=%b taken=%b target=%h ghr=%b, required hit=%b taken=%b target=%h ghr=%b",
                             e.pc, btb_hit_o, predict_taken_o, predict_target_o, ghr_o,
                             e.hit, e.taken, e.target, e.ghr);
                end
            end
        end
    end

    task automatic look(input logic [31:0] pc, input logic h, input logic t,
                        input logic [31:0] tgt, input logic [GB-1:0] g);
        exp_t e;
        pc_i = pc;
        e.hit = h; e.taken = t; e.target = tgt; e.ghr = g; e.pc = pc;
        sb.push_back(e);
        chk = 1'b1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                       input logic br, input logic jmp, input logic [GB-1:0] gh);
        update_valid_i     = 1'b1;
        update_pc_i        = pc;
        update_target_i    = tgt;
        update_taken_i     = taken;
        update_is_branch_i = br;
        update_is_jump_i   = jmp;
        update_ghr_i       = gh;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk                = 1'b0;
        update_valid_i     = 1'b0;
        update_taken_i     = 1'b0;
        update_is_branch_i = 1'b0;
        update_is_jump_i   = 1'b0;
        update_ghr_i       = '0;
    endtask

    initial begin
        reset = 1'b0;
        pc_i = 32'h0;
        update_valid_i = 1'b0; update_pc_i = '0; update_target_i = '0;
        update_taken_i = 1'b0; update_is_branch_i = 1'b0; update_is_jump_i = 1'b0;
        update_ghr_i = '0;
        @(posedge clk); #1;

        // Reset state, then release.
        look(32'h100, 0, 0, 32'h104, 0);                                   tick();
        reset = 1'b1;
        look(32'h100, 0, 0, 32'h104, 0);                                   tick();

        // jal 0x100 -> 0x200; same-cycle lookup sees old contents.
        upd(32'h100, 32'h200, 1, 0, 1, 0); look(32'h100, 0, 0, 32'h104, 0); tick();
        look(32'h100, 1, 1, 32'h200, 0);                                   tick();

        // Branch 0x40 -> 0x10 evicts 0x100 (same index); counter walk 01->10->11->10->01->00->00.
        upd(32'h40, 32'h10, 1, 1, 0, 0); look(32'h40, 0, 0, 32'h44, 0);    tick();
        upd(32'h40, 32'h10, 1, 1, 0, 0); look(32'h40, 1, 1, 32'h10, 0);    tick();
        upd(32'h40, 32'h10, 0, 1, 0, 0); look(32'h100, 0, 0, 32'h104, 0);  tick();
        upd(32'h40, 32'h10, 0, 1, 0, 0); look(32'h40, 1, 1, 32'h10, 0);    tick();
        upd(32'h40, 32'h10, 0, 1, 0, 0); look(32'h40, 1, 0, 32'h10, 0);    tick();
        upd(32'h40, 32'h10, 0, 1, 0, 0); look(32'h40, 1, 0, 32'h10, 0);    tick();

        // update_valid_i low: everything else says "taken jump", must be ignored.
        update_pc_i = 32'h40; update_target_i = 32'h999; update_taken_i = 1'b1;
        update_is_jump_i = 1'b1; update_is_branch_i = 1'b1; update_ghr_i = 5'b11111;
        look(32'h40, 1, 0, 32'h10, 0);                                     tick();
        look(32'h40, 1, 0, 32'h10, 0);                                     tick();

        // Alias: 0x10 and 0x20 share BTB index 0.
        upd(32'h10, 32'h300, 1, 1, 0, 0); look(32'h10, 0, 0, 32'h14, 0);   tick();
        upd(32'h20, 32'h400, 1, 1, 0, 0); look(32'h10, 1, 1, 32'h300, 0);  tick();
        look(32'h10, 0, 0, 32'h14, 0);                                     tick();
        look(32'h20, 1, 1, 32'h400, 0);                                    tick();

        // Same-cycle update/lookup at 0x80.
        upd(32'h80, 32'h500, 1, 1, 0, 0); look(32'h80, 0, 0, 32'h84, 0);   tick();
        look(32'h80, 1, 1, 32'h500, 0);                                    tick();

        // Not-taken branch allocates nothing.
        upd(32'h94, 32'h900, 0, 1, 0, 0); look(32'h94, 0, 0, 32'h98, 0);   tick();
        look(32'h94, 0, 0, 32'h98, 0);                                     tick();

        // Distinct index coexists with index 0.
        upd(32'h84, 32'h600, 1, 0, 1, 0); look(32'h80, 1, 1, 32'h500, 0);  tick();
        look(32'h84, 1, 1, 32'h600, 0);                                    tick();

        // History repair from snapshot.
        upd(32'hC0, 32'h700, 1, 1, 0, 5'b10110); look(32'h84, 1, 1, 32'h600, 0); tick();
        look(32'h84, 1, 1, 32'h600, GHR_AFTER);                            tick();

        // Reset mid-update: state cleared at once, update discarded.
        reset = 1'b0;
        upd(32'h84, 32'hA00, 1, 1, 0, 5'b11111); look(32'h84, 0, 0, 32'h88, 0); tick();
        reset = 1'b1;
        upd(32'h84, 32'h800, 1, 0, 1, 0); look(32'h84, 0, 0, 32'h88, 0);   tick();
        look(32'h84, 1, 1, 32'h800, 0);                                    tick();

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
